// File: rtl/axi_spill_slice.sv
// axi_spill_slice: two-entry spill register that cuts all comb paths of one AXI channel.
// Ports: clk_i/rst_i/clr_i, upstream valid_i/ready_o/data_i, downstream valid_o/ready_i/data_o, fill_o.
module axi_spill_slice #(
  parameter int DATA_WIDTH = 64,
  parameter bit BYPASS     = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            fill_o
);

  if (BYPASS) begin : g_bypass
    logic w_unused;
    assign w_unused = ^{clk_i, rst_i, clr_i};
    assign valid_o  = valid_i;
    assign ready_o  = ready_i;
    assign data_o   = data_i;
    assign fill_o   = 2'd0;
  end else begin : g_slice
    logic                  r_a_full;
    logic                  r_b_full;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_a_from_b;
    logic                  w_ld_a;
    logic                  w_ld_b;
    logic [DATA_WIDTH-1:0] w_a_src;

    assign ready_o  = ~r_b_full & ~clr_i;
    assign valid_o  = r_a_full;
    assign data_o   = r_a;
    assign fill_o   = {1'b0, r_a_full} + {1'b0, r_b_full};

    assign w_in_hs  = valid_i & ready_o;
    assign w_out_hs = r_a_full & ready_i;

    // B only holds data when A is full, so draining B always refills A.
    assign w_a_from_b = w_out_hs & r_b_full;
    assign w_ld_a = w_a_from_b
                  | (w_in_hs & (~r_a_full | w_out_hs));
    assign w_ld_b = w_in_hs & r_a_full & ~w_out_hs;
    assign w_a_src = w_a_from_b ? r_b : data_i;

    always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
        r_a_full <= 1'b0;
        r_b_full <= 1'b0;
      end else begin
        if (w_ld_a)        r_a_full <= 1'b1;
        else if (w_out_hs) r_a_full <= 1'b0;
        if (w_ld_b)          r_b_full <= 1'b1;
        else if (w_a_from_b) r_b_full <= 1'b0;
      end
    end

    // Payload needs no reset; the flags qualify it.
    always_ff @(posedge clk_i) begin
      if (w_ld_a) r_a <= w_a_src;
      if (w_ld_b) r_b <= data_i;
    end
  end

endmodule

// File: tb/tb_axi_spill_slice.sv
// tb_axi_spill_slice: randomized and directed checks of axi_spill_slice against a queue model.
// Ports: none; drives a registered instance (DATA_WIDTH=8) and a bypass instance.
module tb_axi_spill_slice;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       clr_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_i = 8'h00;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic [1:0] fill_o;

  logic       b_valid_i = 1'b0;
  logic       b_ready_o;
  logic [7:0] b_data_i = 8'h00;
  logic       b_valid_o;
  logic       b_ready_i = 1'b0;
  logic [7:0] b_data_o;
  logic [1:0] b_fill_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  bit         m_in_hs;
  bit         m_out_hs;
  logic [7:0] m_out_data;

  always #5 clk = ~clk;

  axi_spill_slice #(.DATA_WIDTH(8), .BYPASS(1'b0)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .fill_o(fill_o)
  );

  axi_spill_slice #(.DATA_WIDTH(8), .BYPASS(1'b1)) dut_byp (
    .clk_i(clk), .rst_i(1'b0), .clr_i(1'b0),
    .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i),
    .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o),
    .fill_o(b_fill_o)
  );

  // Apply inputs for one cycle and advance the FIFO-style reference model.
  task automatic tick(input bit v, input logic [7:0] d, input bit r,
                      input bit c, input bit rs);
    valid_i = v; data_i = d; ready_i = r; clr_i = c; rst_i = rs;
    @(posedge clk);
    m_in_hs    = v && !c && (q.size() < 2);
    m_out_hs   = r && (q.size() > 0);
    m_out_data = (q.size() > 0) ? q[0] : 8'h00;
    if (rs || c) begin
      q.delete();
      m_in_hs = 1'b0;
    end else begin
      if (m_out_hs) void'(q.pop_front());
      if (m_in_hs)  q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset;
    tick(0, 8'h00, 0, 0, 1);
    tick(0, 8'h00, 0, 0, 1);
    n_tests++;
    if (valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b want 0", valid_o);
    end
    n_tests++;
    if (fill_o !== 2'd0) begin
      n_fail++; $display("FAIL reset_fill got %0d want 0", fill_o);
    end
    n_tests++;
    if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b want 1", ready_o);
    end
    tick(0, 8'h00, 0, 0, 0);
  endtask

  task automatic test_streaming;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = 8'h10 + 8'(i);
      tick(1, exp, 1, 0, 0);
      n_tests++;
      if (valid_o !== 1'b1 || data_o !== exp) begin
        n_fail++;
        $display("FAIL stream_data[%0d] got v=%b d=%h want v=1 d=%h",
                 i, valid_o, data_o, exp);
      end
      n_tests++;
      if (ready_o !== 1'b1 || fill_o !== 2'd1) begin
        n_fail++;
        $display("FAIL stream_flow[%0d] got rdy=%b fill=%0d want rdy=1 fill=1",
                 i, ready_o, fill_o);
      end
    end
    tick(0, 8'h00, 1, 0, 0);
    n_tests++;
    if (valid_o !== 1'b0 || fill_o !== 2'd0) begin
      n_fail++;
      $display("FAIL stream_drain got v=%b fill=%0d want v=0 fill=0",
               valid_o, fill_o);
    end
  endtask

  task automatic test_backpressure;
    tick(1, 8'hA1, 0, 0, 0);
    tick(1, 8'hA2, 0, 0, 0);
    tick(1, 8'hA3, 0, 0, 0);
    n_tests++;
    if (fill_o !== 2'd2 || ready_o !== 1'b0 || data_o !== 8'hA1) begin
      n_fail++;
      $display("FAIL bp_full got fill=%0d rdy=%b d=%h want fill=2 rdy=0 d=a1",
               fill_o, ready_o, data_o);
    end
    n_tests++;
    if (q.size() != 2 || q[1] !== 8'hA2) begin
      n_fail++;
      $display("FAIL bp_model got size=%0d want 2 (a3 held upstream)",
               q.size());
    end
    tick(1, 8'hA3, 1, 0, 0);
    n_tests++;
    if (valid_o !== 1'b1 || data_o !== 8'hA2) begin
      n_fail++;
      $display("FAIL bp_second got v=%b d=%h want v=1 d=a2", valid_o, data_o);
    end
    tick(1, 8'hA3, 1, 0, 0);
    n_tests++;
    if (valid_o !== 1'b1 || data_o !== 8'hA3) begin
      n_fail++;
      $display("FAIL bp_third got v=%b d=%h want v=1 d=a3", valid_o, data_o);
    end
    tick(0, 8'h00, 1, 0, 0);
    n_tests++;
    if (valid_o !== 1'b0 || fill_o !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_drain got v=%b fill=%0d want 0 0", valid_o, fill_o);
    end
  endtask

  task automatic test_stability;
    int bad;
    bad = 0;
    tick(1, 8'h55, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1, 8'($urandom), 0, 0, 0);
      if (valid_o !== 1'b1 || data_o !== 8'h55) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stability got %0d unstable cycles want 0", bad);
    end
    tick(0, 8'h00, 1, 0, 0);
    tick(0, 8'h00, 1, 0, 0);
    n_tests++;
    if (fill_o !== 2'd0) begin
      n_fail++; $display("FAIL stab_drain got fill=%0d want 0", fill_o);
    end
  endtask

  task automatic test_flush;
    tick(1, 8'hB1, 0, 0, 0);
    tick(1, 8'hB2, 0, 0, 0);
    valid_i = 1'b1; data_i = 8'hB3; clr_i = 1'b1; ready_i = 1'b0;
    #1;
    n_tests++;
    if (ready_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready got %b want 0", ready_o);
    end
    tick(1, 8'hB3, 0, 1, 0);
    clr_i = 1'b0;
    #1;
    n_tests++;
    if (fill_o !== 2'd0 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty got fill=%0d v=%b want 0 0", fill_o, valid_o);
    end
    tick(1, 8'hB3, 0, 0, 0);
    n_tests++;
    if (valid_o !== 1'b1 || data_o !== 8'hB3 || fill_o !== 2'd1) begin
      n_fail++;
      $display("FAIL flush_next got v=%b d=%h fill=%0d want 1 b3 1",
               valid_o, data_o, fill_o);
    end
    tick(0, 8'h00, 1, 0, 0);
  endtask

  task automatic test_reset_full;
    tick(1, 8'hC1, 0, 0, 0);
    tick(1, 8'hC2, 0, 0, 0);
    tick(1, 8'hC3, 1, 0, 1);
    n_tests++;
    if (valid_o !== 1'b0 || fill_o !== 2'd0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_full got v=%b fill=%0d rdy=%b want 0 0 1",
               valid_o, fill_o, ready_o);
    end
    tick(0, 8'h00, 0, 0, 0);
  endtask

  task automatic test_random;
    int in_cnt, out_cnt, cyc, bad;
    in_cnt = 0; out_cnt = 0; cyc = 0; bad = 0;
    while (out_cnt < 10000 && cyc < 60000) begin
      tick(in_cnt < 10000 ? 1'($urandom) : 1'b0, 8'(in_cnt),
           1'($urandom), 0, 0);
      cyc++;
      if (m_in_hs) in_cnt++;
      if (m_out_hs) begin
        if (m_out_data !== 8'(out_cnt)) bad++;
        out_cnt++;
      end
      if (valid_o !== (q.size() > 0) || fill_o !== 2'(q.size()) ||
          ready_o !== (q.size() < 2)) bad++;
      else if (valid_o && data_o !== q[0]) bad++;
    end
    n_tests++;
    if (out_cnt != 10000) begin
      n_fail++;
      $display("FAIL random_timeout got %0d beats want 10000", out_cnt);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL random_order got %0d errors want 0", bad);
    end
    tick(0, 8'h00, 1, 0, 0);
    tick(0, 8'h00, 1, 0, 0);
  endtask

  task automatic test_bypass;
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      logic       v, r;
      logic [7:0] d;
      v = 1'($urandom); r = 1'($urandom); d = 8'($urandom);
      b_valid_i = v; b_ready_i = r; b_data_i = d;
      #1;
      if (b_valid_o !== v || b_ready_o !== r || b_data_o !== d ||
          b_fill_o !== 2'd0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bypass got %0d errors want 0", bad);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_stability();
    test_flush();
    test_reset_full();
    test_random();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
